// File: rtl/div32x32_seq_if.sv
// Handshake and data bundle for the sequential 32/32 divider.
//   master : drives start/a/b, observes busy/done/quotient/remainder/div_by_zero
//   slave  : the divider side
interface div32x32_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  modport master (
    output start, a, b,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div32x32_seq.sv
// Sequential unsigned 32/32 restoring divider, one quotient bit per cycle.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : div32x32_seq_if.slave
//           start/a/b in; busy, done (1-cycle pulse), quotient, remainder,
//           div_by_zero out. Results hold until the next completion.
// A divide takes 32 CALC cycles plus one DONE cycle; b==0 skips CALC and
// reports quotient=all-ones, remainder=a.
module div32x32_seq (
  input logic           clk,
  input logic           rst_n,
  div32x32_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state_q, state_d;
  logic [32:0] p_q, p_d;       // partial remainder
  logic [31:0] q_q, q_d;       // dividend shifting out, quotient shifting in
  logic [31:0] d_q, d_d;       // divisor
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quotient_q, quotient_d;
  logic [31:0] remainder_q, remainder_d;
  logic        dbz_q, dbz_d;
  logic [32:0] trial;

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    q_d         = q_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    trial       = {p_q[31:0], q_q[31]};

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          q_d   = bus.a;
          d_d   = bus.b;
          p_d   = '0;
          cnt_d = '0;
          if (bus.b == 32'd0) begin
            state_d     = StDone;
            quotient_d  = '1;
            remainder_d = bus.a;
            dbz_d       = 1'b1;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        // 33-bit compare: trial can exceed 2^32 while the divisor cannot.
        if (trial >= {1'b0, d_q}) begin
          p_d = trial - {1'b0, d_q};
          q_d = {q_q[30:0], 1'b1};
        end else begin
          p_d = trial;
          q_d = {q_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          // Results latch on the edge that enters DONE so they are valid with done.
          state_d     = StDone;
          quotient_d  = q_d;
          remainder_d = p_d[31:0];
          dbz_d       = 1'b0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      p_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      q_q         <= q_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == StCalc);
  assign bus.done        = (state_q == StDone);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32x32_seq.sv
// Self-checking bench for div32x32_seq: directed cases plus random pairs
// checked against plain integer division.
module tb_div32x32_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  div32x32_seq_if bus_if ();

  div32x32_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called right after the accepting edge (edge 0). Returns at the negedge of
  // the done cycle. With hold set, start stays high and operands churn.
  task automatic collect(input bit hold, output int done_cyc, output int busy_cnt);
    done_cyc = -1;
    busy_cnt = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (bus_if.busy && bus_if.done) check_eq("busy_done_overlap", 64'd1, 64'd0);
      if (bus_if.busy) busy_cnt++;
      if (bus_if.done) begin
        done_cyc = cyc;
        break;
      end
      if (hold) begin
        bus_if.a = $urandom;
        bus_if.b = $urandom;
      end
    end
    if (done_cyc < 0) check_eq("done_timeout", 64'd0, 64'd1);
  endtask

  // Model: plain integer division; b==0 gives all-ones / dividend.
  task automatic run(input logic [31:0] a, input logic [31:0] b, input bit hold,
                     input string tag);
    int          done_cyc;
    int          busy_cnt;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    exp_q = (b == 0) ? 32'hFFFF_FFFF : a / b;
    exp_r = (b == 0) ? a : a % b;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = a;
    bus_if.b     = b;
    @(posedge clk);
    #1;
    if (!hold) begin
      bus_if.start = 1'b0;
      bus_if.a     = $urandom;
      bus_if.b     = $urandom;
    end
    collect(hold, done_cyc, busy_cnt);
    check_eq({tag, "_done_cyc"}, 64'(done_cyc), (b == 0) ? 64'd1 : 64'd33);
    check_eq({tag, "_busy_cnt"}, 64'(busy_cnt), (b == 0) ? 64'd0 : 64'd32);
    check_eq({tag, "_quot"}, 64'(bus_if.quotient), 64'(exp_q));
    check_eq({tag, "_rem"}, 64'(bus_if.remainder), 64'(exp_r));
    check_eq({tag, "_dbz"}, 64'(bus_if.div_by_zero), 64'(b == 0));
  endtask

  initial begin
    int          done_cyc;
    int          busy_cnt;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] recon;

    n_checks     = 0;
    n_fails      = 0;
    rst_n        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(bus_if.busy), 64'd0);
    check_eq("rst_done", 64'(bus_if.done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_quot", 64'(bus_if.quotient), 64'd0);
    check_eq("post_rst_rem", 64'(bus_if.remainder), 64'd0);
    check_eq("post_rst_dbz", 64'(bus_if.div_by_zero), 64'd0);
    check_eq("post_rst_busy", 64'(bus_if.busy), 64'd0);

    run(32'd100, 32'd7, 1'b0, "d100_7");
    @(negedge clk);
    check_eq("done_single_pulse", 64'(bus_if.done), 64'd0);
    run(32'hFFFF_FFFF, 32'd1, 1'b0, "max_1");
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "max_max");
    run(32'd7, 32'd100, 1'b0, "d7_100");
    run(32'd5, 32'd0, 1'b0, "dbz");
    @(negedge clk);
    check_eq("dbz_held", 64'(bus_if.div_by_zero), 64'd1);
    run(32'd9, 32'd3, 1'b0, "after_dbz");

    // start held high, operands churning during CALC
    run(32'd1000, 32'd33, 1'b1, "held_start");
    bus_if.a = 32'd50;
    bus_if.b = 32'd5;
    @(negedge clk);
    check_eq("b2b_idle_busy", 64'(bus_if.busy), 64'd0);
    check_eq("b2b_idle_done", 64'(bus_if.done), 64'd0);
    check_eq("b2b_held_quot", 64'(bus_if.quotient), 64'd30);
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    @(negedge clk);
    check_eq("b2b_busy_next", 64'(bus_if.busy), 64'd1);
    collect(1'b0, done_cyc, busy_cnt);
    check_eq("b2b_done_cyc", 64'(done_cyc), 64'd32);
    check_eq("b2b_quot", 64'(bus_if.quotient), 64'd10);
    check_eq("b2b_rem", 64'(bus_if.remainder), 64'd0);

    // Asynchronous reset in cycle 15 of CALC
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = 32'd1000;
    bus_if.b     = 32'd33;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    repeat (15) @(negedge clk);
    check_eq("pre_rst_busy", 64'(bus_if.busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_busy", 64'(bus_if.busy), 64'd0);
    check_eq("async_rst_done", 64'(bus_if.done), 64'd0);
    check_eq("async_rst_quot", 64'(bus_if.quotient), 64'd0);
    check_eq("async_rst_rem", 64'(bus_if.remainder), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(32'd12345678, 32'd1000, 1'b0, "after_rst");

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) rb = rb >> $urandom_range(31, 1);
      if (i % 8 == 3) ra = ra >> $urandom_range(31, 1);
      if (rb == 0) rb = 32'd1;
      run(ra, rb, 1'b0, "rand");
      recon = 64'(bus_if.quotient) * 64'(rb) + 64'(bus_if.remainder);
      check_eq("rand_recon", recon, 64'(ra));
      check_eq("rand_rem_lt_b", 64'(bus_if.remainder < rb), 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
